jt6295_cmd_tx: RTL and testbench

//  Host-side command transmitter for the JT6295 CPU write port. Accepts phrase-start and

---
 rtl/jt6295_cmd_tx_pkg.sv | 49 ++++
 rtl/jt6295_cmd_tx_if.sv | 23 ++
 rtl/jt6295_wrpulse.sv | 71 +++++++
 rtl/jt6295_cmd_tx.sv | 118 +++++++++++
 tb/tb_jt6295_cmd_tx.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jt6295_cmd_tx_pkg.sv
// Shared definitions for the JT6295 command transmitter: FSM encodings,
// the latched request record and the CPU-port byte formats.
package jt6295_cmd_tx_pkg;

  localparam int JT6295_START_BIT  = 7;
  localparam int JT6295_STOP_SHIFT = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_WAIT  = 2'd1,
    TX_BYTE1 = 2'd2,
    TX_BYTE2 = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    WP_IDLE  = 2'd0,
    WP_SETUP = 2'd1,
    WP_LOW   = 2'd2,
    WP_GAP   = 2'd3
  } wp_state_e;

  typedef struct packed {
    logic [6:0] phrase;
    logic [3:0] ch;
    logic [3:0] att;
  } req_t;

  typedef struct packed {
    tx_state_e tx;
    wp_state_e wp;
  } dbg_t;

  function automatic logic [7:0] start_byte1(input logic [6:0] phrase);
    logic [7:0] b;
    b = {1'b0, phrase};
    b[JT6295_START_BIT] = 1'b1;
    return b;
  endfunction

  function automatic logic [7:0] start_byte2(input logic [3:0] ch, input logic [3:0] att);
    return {ch, att};
  endfunction

  // Stop byte keeps bit 7 clear so the core cannot mistake it for a phrase start.
  function automatic logic [7:0] stop_byte(input logic [3:0] ch);
    return 8'({1'b0, ch}) << JT6295_STOP_SHIFT;
  endfunction

endpackage

// File: rtl/jt6295_cmd_tx_if.sv
// Request port of the JT6295 command transmitter.
interface jt6295_cmd_tx_if;
  // A request transfers on a rising clk edge where req_valid & req_ready are both 1.
  // The host holds req_valid and all fields stable until that edge; the transmitter
  // latches the fields on it and ignores them afterwards.
  logic       req_valid;
  logic       req_ready;
  logic       req_stop;
  logic [6:0] req_phrase;
  logic [3:0] req_ch;
  logic [3:0] req_att;
  logic       wait_en;

  modport master (
    output req_valid, req_stop, req_phrase, req_ch, req_att, wait_en,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_stop, req_phrase, req_ch, req_att, wait_en,
    output req_ready
  );
endinterface

// File: rtl/jt6295_wrpulse.sv
// One-byte write timer: SETUP (data presented, wrn high), LOW (strobe), GAP (recovery).
module jt6295_wrpulse
  import jt6295_cmd_tx_pkg::*;
#(
  parameter int LOW_CYC  = 4,
  parameter int HIGH_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [7:0] wr_byte,
  output logic       wrn,
  output logic [7:0] dout,
  output logic       fin,
  output wp_state_e  state_dbg
);

  localparam int CMAX = (LOW_CYC > HIGH_CYC) ? LOW_CYC : HIGH_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  wp_state_e     state;
  logic [CW-1:0] cnt;

  assign state_dbg = state;

  // go is only raised when idle or on the last GAP cycle, so it may pre-empt the GAP exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WP_IDLE;
      wrn   <= 1'b1;
      dout  <= 8'h00;
      fin   <= 1'b0;
      cnt   <= '0;
    end else begin
      fin <= 1'b0;
      if (go) begin
        state <= WP_SETUP;
        dout  <= wr_byte;
        wrn   <= 1'b1;
      end else begin
        case (state)
          WP_SETUP: begin
            state <= WP_LOW;
            wrn   <= 1'b0;
            cnt   <= CW'(LOW_CYC - 1);
          end
          WP_LOW: begin
            if (cnt == '0) begin
              state <= WP_GAP;
              wrn   <= 1'b1;
              cnt   <= CW'(HIGH_CYC - 1);
              fin   <= (HIGH_CYC == 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          WP_GAP: begin
            if (cnt == '0) begin
              state <= WP_IDLE;
            end else begin
              cnt <= cnt - 1'b1;
              fin <= (cnt == CW'(1));
            end
          end
          default: state <= WP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/jt6295_cmd_tx.sv
// Host-side JT6295 command transmitter: accepts start/stop requests, optionally waits
// for the target channels to go idle, and sequences one or two timed byte writes.
module jt6295_cmd_tx
  import jt6295_cmd_tx_pkg::*;
#(
  parameter int LOW_CYC  = 4,
  parameter int HIGH_CYC = 4,
  parameter int TMO_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  jt6295_cmd_tx_if.slave     rq,
  input  logic [3:0]         busy,
  output logic               wrn,
  output logic [7:0]         dout,
  output logic               tx_busy,
  output logic               done,
  output logic               err,
  output dbg_t               dbg
);

  // Last waiting cycle before the counter would reach 2**TMO_W-1.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  tx_state_e        state;
  req_t             req_q;
  logic [TMO_W-1:0] tmo;
  logic             accept;
  logic             wait_pass;
  logic             go;
  logic [7:0]       wr_byte;
  logic             fin;
  wp_state_e        wp_state;

  assign rq.req_ready = (state == TX_IDLE) & ~rst;
  assign accept       = rq.req_valid & rq.req_ready;
  assign wait_pass    = ((busy & req_q.ch) == 4'b0000);
  assign tx_busy      = (state != TX_IDLE);
  // Stops skip BYTE1, so the byte sent from BYTE2 is always the last one.
  assign done         = fin & (state == TX_BYTE2);
  assign dbg          = '{tx: state, wp: wp_state};

  always_comb begin
    go      = 1'b0;
    wr_byte = 8'h00;
    case (state)
      TX_IDLE: begin
        if (accept && (rq.req_stop || !rq.wait_en)) begin
          go      = 1'b1;
          wr_byte = rq.req_stop ? stop_byte(rq.req_ch) : start_byte1(rq.req_phrase);
        end
      end
      TX_WAIT: begin
        if (wait_pass) begin
          go      = 1'b1;
          wr_byte = start_byte1(req_q.phrase);
        end
      end
      TX_BYTE1: begin
        if (fin) begin
          go      = 1'b1;
          wr_byte = start_byte2(req_q.ch, req_q.att);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TX_IDLE;
      req_q <= '0;
      tmo   <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (accept) begin
            req_q <= '{phrase: rq.req_phrase, ch: rq.req_ch, att: rq.req_att};
            tmo   <= '0;
            if (rq.req_stop)      state <= TX_BYTE2;
            else if (rq.wait_en)  state <= TX_WAIT;
            else                  state <= TX_BYTE1;
          end
        end
        TX_WAIT: begin
          if (wait_pass) begin
            state <= TX_BYTE1;
          end else if (tmo == TMO_LAST) begin
            err   <= 1'b1;
            state <= TX_IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        TX_BYTE1: if (fin) state <= TX_BYTE2;
        TX_BYTE2: if (fin) state <= TX_IDLE;
        default:  state <= TX_IDLE;
      endcase
    end
  end

  jt6295_wrpulse #(
    .LOW_CYC  (LOW_CYC),
    .HIGH_CYC (HIGH_CYC)
  ) u_wrpulse (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .wr_byte   (wr_byte),
    .wrn       (wrn),
    .dout      (dout),
    .fin       (fin),
    .state_dbg (wp_state)
  );

endmodule

// File: tb/tb_jt6295_cmd_tx.sv
// Directed bench for jt6295_cmd_tx: expected writes/done events are queued by the
// driver and consumed by a negedge monitor that also models the 6295 receiver.
module tb_jt6295_cmd_tx;
  import jt6295_cmd_tx_pkg::*;

  localparam int LOW  = 4;
  localparam int HIGH = 4;
  localparam logic [9:0] EV_DONE = 10'h100;
  localparam logic [9:0] EV_ERR  = 10'h200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] busy = 4'h0;
  logic       wrn, tx_busy, done, err;
  logic [7:0] dout;
  dbg_t       dbg;

  logic [3:0] busy_t = 4'hf;
  logic       wrn_t, tx_busy_t, done_t, err_t;
  logic [7:0] dout_t;
  dbg_t       dbg_t_o;

  jt6295_cmd_tx_if ifc();
  jt6295_cmd_tx_if ifc_t();

  jt6295_cmd_tx #(.LOW_CYC(LOW), .HIGH_CYC(HIGH), .TMO_W(16)) dut (
    .clk(clk), .rst(rst), .rq(ifc), .busy(busy), .wrn(wrn), .dout(dout),
    .tx_busy(tx_busy), .done(done), .err(err), .dbg(dbg)
  );

  jt6295_cmd_tx #(.LOW_CYC(LOW), .HIGH_CYC(HIGH), .TMO_W(4)) dut_t (
    .clk(clk), .rst(rst), .rq(ifc_t), .busy(busy_t), .wrn(wrn_t), .dout(dout_t),
    .tx_busy(tx_busy_t), .done(done_t), .err(err_t), .dbg(dbg_t_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  event acc_ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input string nm, input logic [9:0] act);
    if (exp_q.size() == 0) check({nm, "_unexpected"}, {22'h0, act}, 32'hffff_ffff);
    else                   check(nm, {22'h0, act}, {22'h0, exp_q.pop_front()});
  endtask

  // ---------------- monitor + receiver model ----------------
  logic       prev_wrn = 1'b1;
  logic       seen_byte = 1'b0;
  int         low_run = 0;
  int         high_run = 0;
  logic [7:0] low_byte = 8'h00;
  logic       armed = 1'b0;
  logic [6:0] rx_phrase = 7'h0, held_phrase = 7'h0;
  logic [3:0] rx_ch = 4'h0, rx_att = 4'h0, rx_stop_ch = 4'h0;
  int         done_cyc = -100;

  always @(negedge clk) begin
    if (rst) begin
      prev_wrn  = 1'b1;
      seen_byte = 1'b0;
      armed     = 1'b0;
      high_run  = 0;
      low_run   = 0;
    end else begin
      if (!wrn && prev_wrn) begin
        if (seen_byte) check("wrn_high_gap", (high_run >= HIGH) ? 1 : 0, 1);
        expect_event("byte", {2'b00, dout});
        if (armed) begin
          rx_phrase = held_phrase;
          rx_ch     = dout[7:4];
          rx_att    = dout[3:0];
          armed     = 1'b0;
        end else if (dout[7]) begin
          held_phrase = dout[6:0];
          armed       = 1'b1;
        end else begin
          rx_stop_ch = dout[6:3];
        end
        low_run   = 1;
        low_byte  = dout;
        seen_byte = 1'b1;
      end else if (!wrn) begin
        low_run++;
        check("dout_stable", {24'h0, dout}, {24'h0, low_byte});
      end else if (wrn && !prev_wrn) begin
        check("wrn_low_len", low_run, LOW);
        high_run = 1;
      end else begin
        high_run++;
      end
      if (done) begin
        expect_event("done", EV_DONE);
        done_cyc = cyc;
      end
      if (err) expect_event("err", EV_ERR);
      prev_wrn = wrn;
    end
  end

  logic t_wrn_low = 1'b0;
  logic t_done_seen = 1'b0;
  always @(negedge clk) begin
    if (!rst && !wrn_t) t_wrn_low = 1'b1;
    if (!rst && done_t) t_done_seen = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic stop, input logic [6:0] ph, input logic [3:0] ch,
                           input logic [3:0] att, input logic we);
    ifc.req_stop   = stop;
    ifc.req_phrase = ph;
    ifc.req_ch     = ch;
    ifc.req_att    = att;
    ifc.wait_en    = we;
  endtask

  // Returns with the bench at the negedge of the first cycle after the accept edge.
  task automatic accept_req(input string nm);
    int n;
    n = 0;
    ifc.req_valid = 1'b1;
    while (!ifc.req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_accept"}, ifc.req_ready, 1'b1);
    @(posedge clk);
    ->acc_ev;
    @(negedge clk);
    ifc.req_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = -1;
    for (int k = 0; k < 2000 && lat < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (done) lat = k + 1;
    end
    check({nm, "_latency"}, lat, exp_lat);
  endtask

  task automatic send(input logic stop, input logic [6:0] ph, input logic [3:0] ch,
                      input logic [3:0] att, input logic we, input int exp_lat,
                      input string nm);
    @(negedge clk);
    drive_req(stop, ph, ch, att, we);
    accept_req(nm);
    wait_done(nm, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    ifc.req_valid   = 1'b0;
    ifc_t.req_valid = 1'b0;
    drive_req(1'b0, 7'h0, 4'h0, 4'h0, 1'b0);
    ifc_t.req_stop   = 1'b0;
    ifc_t.req_phrase = 7'h01;
    ifc_t.req_ch     = 4'b0011;
    ifc_t.req_att    = 4'h0;
    ifc_t.wait_en    = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_wrn", wrn, 1'b1);
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_ready", ifc.req_ready, 1'b0);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", ifc.req_ready, 1'b1);

    // stop ch=1010 -> 0x50, done 9 cycles after accept
    exp_q.push_back(10'h050); exp_q.push_back(EV_DONE);
    send(1'b1, 7'h00, 4'b1010, 4'h0, 1'b0, 9, "stop_a");
    check("rx_stop_ch", rx_stop_ch, 4'b1010);

    // start phrase 0x15, ch 1, att 3 -> 0x95, 0x13, done at 18
    exp_q.push_back(10'h095); exp_q.push_back(10'h013); exp_q.push_back(EV_DONE);
    send(1'b0, 7'h15, 4'b0001, 4'h3, 1'b0, 18, "start_a");
    check("rx_phrase", rx_phrase, 7'h15);
    check("rx_ch", rx_ch, 4'b0001);
    check("rx_att", rx_att, 4'h3);

    // wait_en: channel 0 busy for 50 cycles, then one passing WAIT cycle
    busy = 4'b0001;
    exp_q.push_back(10'h0a2); exp_q.push_back(10'h010); exp_q.push_back(EV_DONE);
    fork
      send(1'b0, 7'h22, 4'b0001, 4'h0, 1'b1, 69, "wait_busy");
      begin
        @(acc_ev);
        repeat (51) @(negedge clk);
        busy = 4'b0000;
      end
    join

    // unrelated channel busy does not delay
    busy = 4'b0010;
    exp_q.push_back(10'h0b3); exp_q.push_back(10'h017); exp_q.push_back(EV_DONE);
    send(1'b0, 7'h33, 4'b0001, 4'h7, 1'b1, 19, "wait_other");

    // stop ignores wait_en even with everything busy
    busy = 4'b1111;
    exp_q.push_back(10'h020); exp_q.push_back(EV_DONE);
    send(1'b1, 7'h00, 4'b0100, 4'h0, 1'b1, 9, "stop_wait");

    // start with empty channel mask still sends both bytes
    exp_q.push_back(10'h0c0); exp_q.push_back(10'h005); exp_q.push_back(EV_DONE);
    send(1'b0, 7'h40, 4'b0000, 4'h5, 1'b1, 19, "start_ch0");
    busy = 4'b0000;

    // busy-wait timeout on the TMO_W=4 instance
    begin : tmo_blk
      int lat;
      logic rdy_at_err, txb_at_err;
      lat = -1; rdy_at_err = 1'b0; txb_at_err = 1'b1;
      @(negedge clk);
      check("tmo_ready_before", ifc_t.req_ready, 1'b1);
      ifc_t.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc_t.req_valid = 1'b0;
      for (int k = 0; k < 100 && lat < 0; k++) begin
        if (k > 0) @(negedge clk);
        if (err_t) begin
          lat = k + 1;
          rdy_at_err = ifc_t.req_ready;
          txb_at_err = tx_busy_t;
        end
      end
      check("tmo_err_latency", lat, 16);
      check("tmo_ready_after", rdy_at_err, 1'b1);
      check("tmo_tx_busy_after", txb_at_err, 1'b0);
      check("tmo_no_write", t_wrn_low, 1'b0);
      check("tmo_no_done", t_done_seen, 1'b0);
    end

    // two queued requests: second accepted the cycle after the first done
    begin : queued_blk
      int n;
      exp_q.push_back(10'h010); exp_q.push_back(EV_DONE);
      exp_q.push_back(10'h0ff); exp_q.push_back(10'h08f); exp_q.push_back(EV_DONE);
      @(negedge clk);
      drive_req(1'b1, 7'h00, 4'b0010, 4'h0, 1'b0);
      ifc.req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      drive_req(1'b0, 7'h7f, 4'b1000, 4'hf, 1'b0);
      n = 0;
      while (!ifc.req_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("queued_accept_cycle", cyc - done_cyc, 1);
      @(posedge clk);
      @(negedge clk);
      ifc.req_valid = 1'b0;
      wait_done("queued_second", 18);
    end

    // reset during LOW of byte2: no done, bus released next cycle
    exp_q.push_back(10'h0aa); exp_q.push_back(10'h06c);
    @(negedge clk);
    drive_req(1'b0, 7'h2a, 4'b0110, 4'hc, 1'b0);
    accept_req("rst_mid");
    repeat (11) @(negedge clk);
    check("rst_mid_in_low", wrn, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wrn", wrn, 1'b1);
    check("rst_mid_tx_busy", tx_busy, 1'b0);
    check("rst_mid_done", done, 1'b0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_queue_empty", exp_q.size(), 0);

    // fresh stop after the reset
    exp_q.push_back(10'h008); exp_q.push_back(EV_DONE);
    send(1'b1, 7'h00, 4'b0001, 4'h0, 1'b0, 9, "stop_after_rst");

    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so a stuck handshake still reaches the summary.
  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
